// File: rtl/bus_if_types_pkg.sv
// Shared bus transaction types for master_bus_if-style ports and arbiters.
package bus_if_types_pkg;

  typedef enum logic {
    TT_READ  = 1'b0,
    TT_WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    TS_BYTE = 2'd0,
    TS_HALF = 2'd1,
    TS_WORD = 2'd2
  } tsize_e;

  // Arbiter ownership state; GNTx means master x currently owns the slave.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_2to1.sv
// Two-master / one-slave round-robin bus arbiter with a per-transaction
// watchdog. Grants are registered; completions are forwarded combinationally.
module bus_arbiter_2to1
  import bus_if_types_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_breq,
  input  logic        m1_breq,
  input  logic        m0_bstart,
  input  logic        m1_bstart,
  input  ttype_e      m0_ttype,
  input  ttype_e      m1_ttype,
  input  tsize_e      m0_tsize,
  input  tsize_e      m1_tsize,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_bdone,
  output logic        m1_bdone,
  output logic        m0_berr,
  output logic        m1_berr,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_breq,
  output logic        s_bstart,
  output ttype_e      s_ttype,
  output tsize_e      s_tsize,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_bdone,
  input  logic [31:0] s_rdata
);

  // A TIMEOUT of zero turns the watchdog off entirely.
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] WD_LAST = WD_EN ? TW'(TIMEOUT - 1) : '0;

  arb_state_e    r_state;
  arb_state_e    w_state_next;
  logic          r_last;
  logic          w_last_next;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_next;
  logic          w_sel_m1;
  logic          w_wd_expire;
  logic          w_finish;

  // Slave-side mux: m1 only while it holds the grant, otherwise m0.
  assign w_sel_m1 = (r_state == ARB_GNT1);
  assign s_breq   = m0_breq | m1_breq;
  assign s_ttype  = w_sel_m1 ? m1_ttype : m0_ttype;
  assign s_tsize  = w_sel_m1 ? m1_tsize : m0_tsize;
  assign s_addr   = w_sel_m1 ? m1_addr  : m0_addr;
  assign s_wdata  = w_sel_m1 ? m1_wdata : m0_wdata;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  // Abort fires on the last allowed granted cycle if the slave stays silent.
  assign w_wd_expire = WD_EN && (r_cnt == WD_LAST) && !s_bdone;
  assign w_finish    = s_bdone || w_wd_expire;

  // State, last-granted and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state arbitration and grant-dependent outputs.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    s_bstart     = 1'b0;
    m0_bdone     = 1'b0;
    m1_bdone     = 1'b0;
    m0_berr      = 1'b0;
    m1_berr      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        // On a tie the master that was not granted last wins.
        if (m0_bstart && (!m1_bstart || r_last)) begin
          w_state_next = ARB_GNT0;
          w_last_next  = 1'b0;
          w_cnt_next   = '0;
        end else if (m1_bstart) begin
          w_state_next = ARB_GNT1;
          w_last_next  = 1'b1;
          w_cnt_next   = '0;
        end
      end
      ARB_GNT0: begin
        s_bstart = m0_bstart;
        m0_bdone = w_finish;
        m0_berr  = w_wd_expire;
        if (w_finish) begin
          w_state_next = ARB_IDLE;
        end else begin
          w_cnt_next = r_cnt + TW'(1);
        end
      end
      ARB_GNT1: begin
        s_bstart = m1_bstart;
        m1_bdone = w_finish;
        m1_berr  = w_wd_expire;
        if (w_finish) begin
          w_state_next = ARB_IDLE;
        end else begin
          w_cnt_next = r_cnt + TW'(1);
        end
      end
      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Randomized scoreboard bench for bus_arbiter_2to1: a transaction-level model
// predicts grant order and outcomes; slave and completion monitors check them.
module tb_bus_arbiter_2to1;
  import bus_if_types_pkg::*;

  localparam int TO = 4;

  typedef struct {
    int          m;
    ttype_e      tt;
    tsize_e      ts;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;      // slave delay in cycles after first granted cycle; 15 = never
    bit          err;
    bit          first;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // main DUT (watchdog enabled)
  logic m0_breq, m1_breq, m0_bstart, m1_bstart;
  ttype_e m0_ttype, m1_ttype, s_ttype;
  tsize_e m0_tsize, m1_tsize, s_tsize;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic m0_bdone, m1_bdone, m0_berr, m1_berr;
  logic s_breq, s_bstart, s_bdone;
  logic [31:0] s_addr, s_wdata, s_rdata;

  // second DUT (watchdog disabled), m1 side tied off
  logic n_m0_bstart, n_s_bdone;
  logic [31:0] n_m0_addr, n_s_rdata;
  logic n_m0_bdone, n_m1_bdone, n_m0_berr, n_m1_berr, n_s_breq, n_s_bstart;
  logic [31:0] n_m0_rdata, n_m1_rdata, n_s_addr, n_s_wdata;
  ttype_e n_s_ttype;
  tsize_e n_s_tsize;

  bus_arbiter_2to1 #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(m0_breq), .m1_breq(m1_breq),
    .m0_bstart(m0_bstart), .m1_bstart(m1_bstart),
    .m0_ttype(m0_ttype), .m1_ttype(m1_ttype),
    .m0_tsize(m0_tsize), .m1_tsize(m1_tsize),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_bdone(m0_bdone), .m1_bdone(m1_bdone),
    .m0_berr(m0_berr), .m1_berr(m1_berr),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .s_breq(s_breq), .s_bstart(s_bstart),
    .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_bdone(s_bdone), .s_rdata(s_rdata)
  );

  bus_arbiter_2to1 #(.TIMEOUT(0), .TW(8)) dut_nw (
    .clk(clk), .rst_n(rst_n),
    .m0_breq(n_m0_bstart), .m1_breq(1'b0),
    .m0_bstart(n_m0_bstart), .m1_bstart(1'b0),
    .m0_ttype(TT_READ), .m1_ttype(TT_READ),
    .m0_tsize(TS_WORD), .m1_tsize(TS_WORD),
    .m0_addr(n_m0_addr), .m1_addr(32'h0),
    .m0_wdata(32'h0), .m1_wdata(32'h0),
    .m0_bdone(n_m0_bdone), .m1_bdone(n_m1_bdone),
    .m0_berr(n_m0_berr), .m1_berr(n_m1_berr),
    .m0_rdata(n_m0_rdata), .m1_rdata(n_m1_rdata),
    .s_breq(n_s_breq), .s_bstart(n_s_bstart),
    .s_ttype(n_s_ttype), .s_tsize(n_s_tsize),
    .s_addr(n_s_addr), .s_wdata(n_s_wdata),
    .s_bdone(n_s_bdone), .s_rdata(n_s_rdata)
  );

  int ntot = 0;
  int nbad = 0;
  int cyc = 0;
  int batch_cyc = 0;
  int last_done = 0;
  int mdl_last = 1;
  txn_t q0[$];
  txn_t q1[$];
  txn_t exp_done[$];
  txn_t exp_slv[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic txn_t mk(int m, ttype_e tt, tsize_e ts, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, int k);
    txn_t t;
    t.m = m; t.tt = tt; t.ts = ts; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.k = k; t.first = 1'b0;
    t.err = (TO != 0) && (k >= TO);
    return t;
  endfunction

  function automatic txn_t rnd_txn(int m);
    int r;
    int k;
    ttype_e tt;
    r  = int'($urandom_range(0, 9));
    k  = (r < 7) ? int'($urandom_range(1, TO - 1)) : ((r < 8) ? TO : 15);
    tt = ($urandom_range(0, 1) == 0) ? TT_READ : TT_WRITE;
    return mk(m, tt, tsize_e'($urandom_range(0, 2)), $urandom, $urandom, $urandom, k);
  endfunction

  task automatic drive(int m, bit on, txn_t t);
    if (m == 0) begin
      m0_bstart = on; m0_breq = on;
      if (on) begin m0_ttype = t.tt; m0_tsize = t.ts; m0_addr = t.addr; m0_wdata = t.wdata; end
    end else begin
      m1_bstart = on; m1_breq = on;
      if (on) begin m1_ttype = t.tt; m1_tsize = t.ts; m1_addr = t.addr; m1_wdata = t.wdata; end
    end
  endtask

  // Model: while both masters wait, grants alternate away from the last winner.
  task automatic run_batch();
    int a = 0;
    int b = 0;
    int i0 = 0;
    int i1 = 0;
    int guard = 0;
    bit firstf = 1'b1;
    bit d0, d1;
    txn_t t;
    while (a < q0.size() || b < q1.size()) begin
      int pick;
      if (a < q0.size() && b < q1.size()) pick = 1 - mdl_last;
      else if (a < q0.size()) pick = 0;
      else pick = 1;
      if (pick == 0) begin t = q0[a]; a++; end
      else begin t = q1[b]; b++; end
      t.first = firstf;
      firstf = 1'b0;
      mdl_last = pick;
      exp_done.push_back(t);
      exp_slv.push_back(t);
    end
    @(posedge clk); #1;
    if (q0.size() > 0) drive(0, 1'b1, q0[0]);
    if (q1.size() > 0) drive(1, 1'b1, q1[0]);
    batch_cyc = cyc;
    while ((i0 < q0.size() || i1 < q1.size()) && guard < 400) begin
      @(negedge clk);
      d0 = m0_bdone; d1 = m1_bdone;
      @(posedge clk); #1;
      guard++;
      if (d0 && i0 < q0.size()) begin
        i0++;
        if (i0 < q0.size()) drive(0, 1'b1, q0[i0]); else drive(0, 1'b0, q0[0]);
      end
      if (d1 && i1 < q1.size()) begin
        i1++;
        if (i1 < q1.size()) drive(1, 1'b1, q1[i1]); else drive(1, 1'b0, q1[0]);
      end
    end
    chk("batch_timeout", 32'(guard >= 400), 32'd0);
    drive(0, 1'b0, t); drive(1, 1'b0, t);
    repeat (4) @(posedge clk);
    chk("batch_drain", 32'(exp_done.size()), 32'd0);
    exp_done.delete();
    exp_slv.delete();
    q0.delete();
    q1.delete();
  endtask

  // Completion monitor: pops the expected outcome on every bdone pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("done_protocol", 32'((m0_bdone && m1_bdone) || (m0_berr && !m0_bdone) ||
                               (m1_berr && !m1_bdone)), 32'd0);
      if (m0_bdone || m1_bdone) begin
        if (exp_done.size() == 0) begin
          chk("unexpected_bdone", {30'd0, m1_bdone, m0_bdone}, 32'd0);
        end else begin
          txn_t e;
          e = exp_done.pop_front();
          chk("done_master", 32'(m1_bdone), 32'(e.m));
          chk("done_berr", 32'(m1_bdone ? m1_berr : m0_berr), 32'(e.err));
          if (!e.err) chk("done_rdata", m1_bdone ? m1_rdata : m0_rdata, e.rdata);
        end
        last_done = cyc;
      end
    end
  end

  // Slave emulation: checks each request it sees and answers after e.k cycles.
  initial begin
    bit sl_busy = 1'b0;
    bit sl_fire = 1'b0;
    int sl_k = 0;
    int sl_cnt = 0;
    logic [31:0] sl_rdata = '0;
    txn_t e;
    s_bdone = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      s_bdone = sl_fire;
      if (sl_fire) s_rdata = sl_rdata;
      sl_fire = 1'b0;
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        sl_busy = 1'b0;
      end else begin
        if (sl_busy) begin
          if (s_bdone) sl_busy = 1'b0;
          else if (sl_k == 15 && !s_bstart) sl_busy = 1'b0;
          else begin
            sl_cnt++;
            if (sl_k != 15 && sl_cnt == sl_k - 1) sl_fire = 1'b1;
          end
        end
        if (!sl_busy && s_bstart && !s_bdone) begin
          if (exp_slv.size() == 0) begin
            chk("unexpected_start", 32'(s_bstart), 32'd0);
            e = mk(0, TT_READ, TS_WORD, 32'h0, 32'h0, 32'h0, 1);
          end else begin
            e = exp_slv.pop_front();
            chk("slv_addr", s_addr, e.addr);
            chk("slv_wdata", s_wdata, e.wdata);
            chk("slv_ttype", 32'(s_ttype), 32'(e.tt));
            chk("slv_tsize", 32'(s_tsize), 32'(e.ts));
            chk("slv_start_cycle", 32'(cyc), e.first ? 32'(batch_cyc + 1) : 32'(last_done + 2));
          end
          sl_k = e.k; sl_rdata = e.rdata; sl_cnt = 0; sl_busy = 1'b1;
          if (sl_k == 1) sl_fire = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int badc;
    txn_t t;
    rst_n = 1'b0;
    m0_breq = 1'b1; m1_breq = 1'b1; m0_bstart = 1'b1; m1_bstart = 1'b1;
    m0_ttype = TT_WRITE; m1_ttype = TT_READ; m0_tsize = TS_HALF; m1_tsize = TS_BYTE;
    m0_addr = 32'h1111_2222; m1_addr = 32'h3333_4444;
    m0_wdata = 32'h5555_6666; m1_wdata = 32'h7777_8888;
    n_m0_bstart = 1'b0; n_m0_addr = '0; n_s_bdone = 1'b0; n_s_rdata = '0;
    repeat (2) @(posedge clk); #1;
    // reset state, requests present but held off
    chk("rst_s_bstart", 32'(s_bstart), 32'd0);
    chk("rst_m0_bdone", 32'(m0_bdone), 32'd0);
    chk("rst_m1_bdone", 32'(m1_bdone), 32'd0);
    chk("rst_berr", {30'd0, m1_berr, m0_berr}, 32'd0);
    chk("rst_s_addr", s_addr, 32'h1111_2222);
    chk("rst_s_wdata", s_wdata, 32'h5555_6666);
    chk("rst_s_ttype", 32'(s_ttype), 32'(TT_WRITE));
    chk("rst_s_breq", 32'(s_breq), 32'd1);
    m0_bstart = 1'b0; m1_bstart = 1'b0; m0_breq = 1'b0; m1_breq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last = 1;

    // simultaneous from reset: m0 read first, then m1 write
    q0.push_back(mk(0, TT_READ, TS_WORD, 32'h100, 32'h0, 32'hCAFE_F00D, 3));
    q1.push_back(mk(1, TT_WRITE, TS_WORD, 32'h2000, 32'h1234_5678, 32'h0, 2));
    run_batch();
    // single read alone
    q0.push_back(mk(0, TT_READ, TS_WORD, 32'h100, 32'h0, 32'hCAFE_F00D, 3));
    run_batch();
    // round-robin, continuous requests
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rnd_txn(0));
      q1.push_back(mk(1, TT_READ, TS_WORD, $urandom, $urandom, $urandom, 2));
    end
    q0[0].k = 1; q0[0].err = 1'b0; q0[1].k = 2; q0[1].err = 1'b0;
    run_batch();
    // watchdog abort on m1 with a late slave response one cycle after
    q1.push_back(mk(1, TT_READ, TS_WORD, 32'h0000_4000, 32'h0, 32'h0BAD_0BAD, TO));
    run_batch();

    // reset mid-grant
    t = mk(0, TT_READ, TS_WORD, 32'h0000_8000, 32'h0, 32'h0, 15);
    t.first = 1'b1;
    exp_slv.push_back(t);
    @(posedge clk); #1;
    drive(0, 1'b1, t);
    batch_cyc = cyc;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_s_bstart", 32'(s_bstart), 32'd0);
    chk("midrst_bdone", {30'd0, m1_bdone, m0_bdone}, 32'd0);
    drive(0, 1'b0, t);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mdl_last = 1;
    exp_slv.delete();
    exp_done.delete();
    q1.push_back(mk(1, TT_WRITE, TS_BYTE, 32'h0000_9000, 32'hA5A5_5A5A, 32'h0, 2));
    run_batch();

    // randomized batches
    for (int n = 0; n < 40; n++) begin
      int c0 = int'($urandom_range(0, 3));
      int c1 = int'($urandom_range(0, 3));
      if (c0 == 0 && c1 == 0) c0 = 1;
      for (int i = 0; i < c0; i++) q0.push_back(rnd_txn(0));
      for (int i = 0; i < c1; i++) q1.push_back(rnd_txn(1));
      run_batch();
    end

    // disabled watchdog: grant held through 1000 silent cycles
    @(posedge clk); #1;
    n_m0_bstart = 1'b1; n_m0_addr = 32'h0000_0300;
    @(posedge clk);
    badc = 0;
    for (int i = 0; i < 999; i++) begin
      @(negedge clk);
      if (n_s_bstart !== 1'b1 || n_m0_bdone !== 1'b0 || n_m0_berr !== 1'b0 ||
          n_s_addr !== 32'h0000_0300) badc++;
      @(posedge clk);
    end
    chk("nw_hold_cycles_bad", 32'(badc), 32'd0);
    #1;
    n_s_bdone = 1'b1; n_s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("nw_bdone", 32'(n_m0_bdone), 32'd1);
    chk("nw_berr", 32'(n_m0_berr), 32'd0);
    chk("nw_rdata", n_m0_rdata, 32'hDEAD_BEEF);
    chk("nw_m1_bdone", 32'(n_m1_bdone), 32'd0);
    @(posedge clk); #1;
    n_s_bdone = 1'b0; n_m0_bstart = 1'b0;
    @(negedge clk);
    chk("nw_idle_after", 32'(n_s_bstart), 32'd0);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2to1.md
# bus_arbiter_2to1

Two-master, one-slave arbiter that shares a single-ported memory or peripheral slave between the core's instruction bus (master 0) and data bus (master 1). It sits between `rv_core` and any slave that lacks dual ports. It serializes `bstart`/`bdone` transactions with round-robin fairness and a per-transaction watchdog. Master-side signals are flattened `master_bus_if` fields; the slave side drives one `master_bus_if`-shaped port.

## Interface

Parameters:
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `s_bdone` before the arbiter aborts it; 0 disables the watchdog.
- `TW`, default 8: width of the watchdog counter; TIMEOUT < 2^TW.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `m0_breq`, `m1_breq`  in  1  master present; ignored for arbitration, forwarded as `s_breq = m0_breq | m1_breq`.
- `m0_bstart`, `m1_bstart`  in  1  transaction request; level, held until that master's `bdone`.
- `m0_ttype`, `m1_ttype`  in  ttype_e  READ/WRITE.
- `m0_tsize`, `m1_tsize`  in  tsize_e  BYTE/HALF/WORD.
- `m0_addr`, `m1_addr`, `m0_wdata`, `m1_wdata`  in  32  address and write data.
- `m0_bdone`, `m1_bdone`  out  1  one-cycle completion pulse to the owning master.
- `m0_berr`, `m1_berr`  out  1  one-cycle abort pulse, coincident with `bdone`, on watchdog expiry.
- `m0_rdata`, `m1_rdata`  out  32  `s_rdata` broadcast to both; valid only with own `bdone`.
- `s_breq`, `s_bstart`  out  1  to slave.
- `s_ttype`, `s_tsize`, `s_addr`, `s_wdata`  out  as above; muxed from the granted master.
- `s_bdone`  in  1  slave completion pulse.
- `s_rdata`  in  32  slave read data, valid with `s_bdone`.

## Operation

- States: IDLE, GNT0, GNT1, held in a 2-bit register. A `last` register holds the most recently granted master.
- IDLE:
  - No request: stay in IDLE.
  - Only m0 requesting: go to GNT0. Only m1 requesting: go to GNT1.
  - Both requesting: grant the master that is not `last`.
  - On entering a GNT state, load `last` with that master's index and clear the watchdog counter.
- GNTx:
  - `s_bstart = mx_bstart`. `s_ttype`, `s_tsize`, `s_addr` and `s_wdata` come from master x.
  - `mx_bdone = s_bdone`.
  - On `s_bdone`, go to IDLE.
  - The watchdog counter increments each cycle without `s_bdone`. When TIMEOUT ≠ 0 and count == TIMEOUT-1 without `s_bdone`, pulse `mx_bdone` and `mx_berr` and go to IDLE.
- In IDLE, the slave mux selects m0. `s_bstart` is 0, so the slave always sees at least one deasserted cycle between transactions.
- A `s_bdone` arriving in IDLE (late response after an abort) is dropped; neither master's `bdone` pulses.
- If the granted master drops `bstart` before `bdone` (protocol violation), the grant is held until `s_bdone` or watchdog expiry.
- The non-granted master's `bdone` and `berr` are always 0.

## Timing

- Reset values: state IDLE, `last` = 1 (so m0 wins the first tie), counter 0. All `bdone`/`berr` outputs 0 and `s_bstart` 0. `s_addr`, `s_wdata` and `s_ttype` follow m0 combinationally.
- Grant is registered. A `bstart` rising at edge N is seen by the slave from cycle N+1. This adds one cycle of latency per transaction versus a direct connection.
- `mx_bdone` is combinational from `s_bdone` in the same cycle; the arbiter is back in IDLE on the following cycle.
- Back-to-back use: after a completion, a still-requesting other master is granted one cycle later (IDLE cycle in between).
- Reset asserted mid-transaction: state, counter and outputs return to reset values immediately and asynchronously. A slave response arriving after reset is dropped per the IDLE rule.

## Structure

- `ttype_e` and `tsize_e` are taken from `bus_if_types_pkg`.
- The arbiter state enum `arb_state_e` is added to `bus_if_types_pkg` for reuse by future N-master arbiters.
- No sub-module. The watchdog is a local counter in the same module.
- A thin wrapper mapping `master_bus_if` instances onto the flattened ports is a separate file and out of scope here.

## Test plan

- **Single read:** m0 `bstart` addr 0x100, slave returns 0xCAFE_F00D after 3 cycles.
  - Requires `s_bstart` from cycle 1, `m0_bdone` for 1 cycle, and `m0_rdata` = 0xCAFE_F00D.
  - `m1_bdone` stays 0.
- **Simultaneous requests from reset:** m0 and m1 `bstart` at the same edge.
  - m0 is served first, then IDLE for 1 cycle, then m1 (addr 0x2000, WRITE, wdata 0x1234_5678) appears on `s_*`.
- **Round-robin:** both masters request continuously for 4 transactions.
  - Grant order is 0,1,0,1, and no master is served twice in a row while the other waits.
- **Watchdog:** TIMEOUT=4, m1 granted, slave never responds.
  - `m1_bdone` and `m1_berr` pulse in the 4th granted cycle, then IDLE.
  - A `s_bdone` injected one cycle later produces no `bdone` pulse on either master.
- **Reset mid-grant:** drop `rst_n` during GNT0.
  - State is IDLE and `s_bstart` is 0 in the same cycle.
  - After release, a new m1 request is granted normally.
- **Disabled watchdog:** TIMEOUT=0 with a slave that is silent for 1000 cycles.
  - The grant is held, with no `berr`.
  - A `s_bdone` at cycle 1000 completes the transaction normally.
